// File: rtl/mem_stage.sv
// Memory stage of the core_lapido pipeline.
// Resolves branches and flag jumps, picks the next fetch PC, and performs a
// single-cycle data-memory access. It also forwards the ALU result, the
// immediate, the destination register and the write-back select to MEM/WB.
// The data memory writes on the clock edge and reads combinationally.
// Reset clears the memory asynchronously, so it is built from flops rather
// than block RAM.
module mem_stage #(
    parameter int PC_WIDTH  = 26,
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                is_branch,
    input  logic                sel_jflag_branch,
    input  logic                sel_jt_jf,
    input  logic                sel_beq_bne,
    input  logic                mem_write,
    input  logic [4:0]          flag_code,
    input  logic [5:0]          flags_in,
    input  logic [PC_WIDTH-1:0] in_next_pc,
    input  logic [PC_WIDTH-1:0] branch_addr,
    input  logic [31:0]         alu_res,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_data,
    input  logic [4:0]          reg_dst,
    input  logic [31:0]         immediate,
    input  logic [1:0]          wb_res_mux,
    output logic                branch_taken,
    output logic [PC_WIDTH-1:0] out_next_pc,
    output logic [31:0]         out_mem_data,
    output logic [31:0]         out_alu_res,
    output logic [31:0]         out_im,
    output logic [4:0]          out_reg_dst,
    output logic [1:0]          out_wb_res_mux
);

    // Flag indices into flags_in.
    localparam logic [4:0] FL_TRUE     = 5'd0;
    localparam logic [4:0] FL_NEG      = 5'd1;
    localparam logic [4:0] FL_ZERO     = 5'd2;
    localparam logic [4:0] FL_NEGZERO  = 5'd3;
    localparam logic [4:0] FL_CARRY    = 5'd4;
    localparam logic [4:0] FL_OVERFLOW = 5'd5;

    logic                 flag_sel;
    logic                 cond_true;
    logic [ADDR_BITS-1:0] mem_index;
    logic [MEM_DEPTH-1:0] word_we;
    logic [31:0]          mem_array [MEM_DEPTH];

    // Select the flag that jt/jf tests. Codes beyond OVERFLOW read as 0.
    always_comb begin
        flag_sel = 1'b0;
        case (flag_code)
            FL_TRUE:     flag_sel = flags_in[0];
            FL_NEG:      flag_sel = flags_in[1];
            FL_ZERO:     flag_sel = flags_in[2];
            FL_NEGZERO:  flag_sel = flags_in[3];
            FL_CARRY:    flag_sel = flags_in[4];
            FL_OVERFLOW: flag_sel = flags_in[5];
            default:     flag_sel = 1'b0;
        endcase
    end

    // Resolve the branch condition. The jt/beq forms take the branch on a
    // set flag, and the jf/bne forms take it on a clear flag. beq/bne always
    // test the ZERO flag and ignore flag_code.
    always_comb begin
        cond_true = 1'b0;
        if (sel_jflag_branch) begin
            cond_true = sel_beq_bne ? ~flags_in[2] : flags_in[2];
        end else begin
            cond_true = sel_jt_jf ? ~flag_sel : flag_sel;
        end
        branch_taken = is_branch & cond_true;
        out_next_pc  = branch_taken ? branch_addr : in_next_pc;
    end

    // Word index ignores the upper address bits, so addresses wrap.
    assign mem_index = mem_addr[ADDR_BITS-1:0];

    // One write-enable per word, decoded from the wrapped index.
    generate
        for (genvar gi = 0; gi < MEM_DEPTH; gi++) begin : g_word_we
            assign word_we[gi] = mem_write && (mem_index == ADDR_BITS'(gi));
        end
    endgenerate

    // Data memory storage. Reset clears every word and blocks writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_array[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                if (word_we[i]) begin
                    mem_array[i] <= mem_data;
                end
            end
        end
    end

    // The read is combinational, so a same-cycle write is seen after the edge.
    assign out_mem_data = mem_array[mem_index];

    // MEM/WB passthroughs. They are unaffected by reset.
    assign out_alu_res    = alu_res;
    assign out_im         = immediate;
    assign out_reg_dst    = reg_dst;
    assign out_wb_res_mux = wb_res_mux;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage. Branch resolution is checked from a
// vector table. Memory and reset behaviour are checked with hand-written
// sequences.
module tb_mem_stage;

    localparam int PC_WIDTH  = 26;
    localparam int MEM_DEPTH = 256;
    localparam int ADDR_BITS = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                is_branch, sel_jflag_branch, sel_jt_jf, sel_beq_bne;
    logic                mem_write;
    logic [4:0]          flag_code;
    logic [5:0]          flags_in;
    logic [PC_WIDTH-1:0] in_next_pc, branch_addr;
    logic [31:0]         alu_res, mem_addr, mem_data, immediate;
    logic [4:0]          reg_dst;
    logic [1:0]          wb_res_mux;
    logic                branch_taken;
    logic [PC_WIDTH-1:0] out_next_pc;
    logic [31:0]         out_mem_data, out_alu_res, out_im;
    logic [4:0]          out_reg_dst;
    logic [1:0]          out_wb_res_mux;

    int errors = 0;
    int checks = 0;

    mem_stage #(.PC_WIDTH(PC_WIDTH), .MEM_DEPTH(MEM_DEPTH), .ADDR_BITS(ADDR_BITS)) dut (
        .clk(clk), .rst(rst),
        .is_branch(is_branch), .sel_jflag_branch(sel_jflag_branch),
        .sel_jt_jf(sel_jt_jf), .sel_beq_bne(sel_beq_bne),
        .mem_write(mem_write), .flag_code(flag_code), .flags_in(flags_in),
        .in_next_pc(in_next_pc), .branch_addr(branch_addr),
        .alu_res(alu_res), .mem_addr(mem_addr), .mem_data(mem_data),
        .reg_dst(reg_dst), .immediate(immediate), .wb_res_mux(wb_res_mux),
        .branch_taken(branch_taken), .out_next_pc(out_next_pc),
        .out_mem_data(out_mem_data), .out_alu_res(out_alu_res), .out_im(out_im),
        .out_reg_dst(out_reg_dst), .out_wb_res_mux(out_wb_res_mux)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       br;
        logic       jflag;
        logic       jt_jf;
        logic       beq_bne;
        logic [4:0] code;
        logic [5:0] flags;
        logic       exp_taken;
    } br_vec_t;

    br_vec_t vecs [64];
    int      nvec = 0;

    task automatic add_vec(input logic br, input logic jflag, input logic jt_jf,
                           input logic beq_bne, input logic [4:0] code,
                           input logic [5:0] flags, input logic exp_taken);
        vecs[nvec].br        = br;
        vecs[nvec].jflag     = jflag;
        vecs[nvec].jt_jf     = jt_jf;
        vecs[nvec].beq_bne   = beq_bne;
        vecs[nvec].code      = code;
        vecs[nvec].flags     = flags;
        vecs[nvec].exp_taken = exp_taken;
        nvec++;
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Drive one write on the next rising edge and release mem_write afterwards.
    task automatic mem_wr(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        mem_addr  = addr;
        mem_data  = data;
        mem_write = 1'b1;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
    endtask

    task automatic mem_rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        mem_addr = addr;
        #1;
        check32(name, out_mem_data, exp);
    endtask

    logic [PC_WIDTH-1:0] exp_pc;
    int                  nz;

    initial begin
        rst = 1'b1;
        is_branch = 0; sel_jflag_branch = 0; sel_jt_jf = 0; sel_beq_bne = 0;
        mem_write = 0; flag_code = 0; flags_in = 0;
        in_next_pc = '0; branch_addr = '0;
        alu_res = 32'h1234_5678; mem_addr = 0; mem_data = 0;
        immediate = 32'hCAFE_F00D; reg_dst = 5'd17; wb_res_mux = 2'd2;

        // Reset state: memory reads 0 and passthroughs still follow the inputs.
        #2;
        check32("reset_mem_addr0", out_mem_data, 32'd0);
        check32("reset_pass_alu", out_alu_res, 32'h1234_5678);
        check32("reset_pass_im", out_im, 32'hCAFE_F00D);
        check32("reset_pass_rd", {27'd0, out_reg_dst}, 32'd17);
        check32("reset_pass_wb", {30'd0, out_wb_res_mux}, 32'd2);

        // Branch vector table.
        for (int c = 0; c < 6; c++) begin
            add_vec(1'b0, c[0], c[1], c[2], 5'(c), 6'b111111, 1'b0);
            add_vec(1'b0, c[1], ~c[0], c[0], 5'(c), 6'b000000, 1'b0);
        end
        add_vec(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'b000001, 1'b1);
        add_vec(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 6'b000001, 1'b0);
        for (int c = 1; c < 6; c++) begin
            add_vec(1'b1, 1'b0, 1'b0, 1'b0, 5'(c), 6'(1 << c), 1'b1);
            add_vec(1'b1, 1'b0, 1'b1, 1'b0, 5'(c), 6'(1 << c), 1'b0);
            add_vec(1'b1, 1'b0, 1'b0, 1'b0, 5'(c), 6'b000000, 1'b0);
            add_vec(1'b1, 1'b0, 1'b1, 1'b0, 5'(c), 6'b000000, 1'b1);
            // A flag other than the selected one must not matter.
            add_vec(1'b1, 1'b0, 1'b0, 1'b0, 5'(c), ~6'(1 << c), 1'b0);
        end
        add_vec(1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 6'b111111, 1'b0);
        add_vec(1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 6'b111111, 1'b1);
        add_vec(1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 6'b111111, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 6'b000010, 1'b1);
        add_vec(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 6'b000100, 1'b1);
        add_vec(1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 6'b000100, 1'b0);
        add_vec(1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 6'b111011, 1'b0);
        add_vec(1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 6'b111011, 1'b1);

        for (int i = 0; i < nvec; i++) begin
            is_branch        = vecs[i].br;
            sel_jflag_branch = vecs[i].jflag;
            sel_jt_jf        = vecs[i].jt_jf;
            sel_beq_bne      = vecs[i].beq_bne;
            flag_code        = vecs[i].code;
            flags_in         = vecs[i].flags;
            in_next_pc       = PC_WIDTH'(26'h100 + i);
            branch_addr      = PC_WIDTH'(26'h2A0000 + 3 * i);
            exp_pc           = vecs[i].exp_taken ? branch_addr : in_next_pc;
            #1;
            check32($sformatf("br%0d_taken", i), {31'd0, branch_taken}, {31'd0, vecs[i].exp_taken});
            check32($sformatf("br%0d_pc", i), {6'd0, out_next_pc}, {6'd0, exp_pc});
        end
        is_branch = 0;

        // Memory: release reset and perform basic accesses.
        @(negedge clk);
        rst = 1'b0;
        mem_rd_check("rd5_after_reset", 32'd5, 32'd0);

        // The read keeps the old word until the edge and shows the new one after it.
        @(negedge clk);
        mem_addr = 32'd5; mem_data = 32'hDEAD_BEEF; mem_write = 1'b1;
        #1;
        check32("rd5_before_edge", out_mem_data, 32'd0);
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        check32("rd5_after_edge", out_mem_data, 32'hDEAD_BEEF);

        mem_wr(32'd6, 32'h0000_0066);
        mem_rd_check("rd6", 32'd6, 32'h0000_0066);
        mem_rd_check("rd5_kept", 32'd5, 32'hDEAD_BEEF);

        // Aliased address overwrites word 5.
        mem_wr(32'd5 + MEM_DEPTH, 32'h1357_9BDF);
        mem_rd_check("rd5_wrapped", 32'd5, 32'h1357_9BDF);
        mem_rd_check("rd_alias_hi", 32'hFFFF_FF05, 32'h1357_9BDF);

        // With mem_write low, the word is unchanged.
        @(negedge clk);
        mem_addr = 32'd5; mem_data = 32'hFFFF_FFFF; mem_write = 1'b0;
        @(posedge clk);
        #1;
        check32("rd5_no_write", out_mem_data, 32'h1357_9BDF);

        mem_wr(32'd255, 32'hA5A5_5A5A);
        mem_rd_check("rd255", 32'd255, 32'hA5A5_5A5A);

        // Asynchronous reset between edges clears the array immediately.
        mem_addr = 32'd5;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check32("rst_mid_rd5", out_mem_data, 32'd0);
        mem_rd_check("rst_mid_rd255", 32'd255, 32'd0);

        // Writes are blocked while reset is held.
        mem_addr = 32'd9; mem_data = 32'h9999_9999; mem_write = 1'b1;
        @(posedge clk);
        #1;
        check32("rst_blocks_write", out_mem_data, 32'd0);
        mem_write = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        nz = 0;
        for (int a = 0; a < MEM_DEPTH; a++) begin
            mem_addr = 32'(a);
            #1;
            if (out_mem_data !== 32'd0) nz++;
        end
        check32("all_words_zero", 32'(nz), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
